// File: rtl/rc4_decrypt_engine_if.sv
// Port bundle of the RC4 engine: start/done handshake, key, S-memory, ciphertext ROM, plaintext RAM.
// master = engine side, slave = controller/memory side.
interface rc4_decrypt_engine_if #(
   parameter int KEY_BYTES = 3
);
   logic                   start;
   logic [8*KEY_BYTES-1:0] key;
   logic                   busy;
   logic                   done;
   logic                   fail;
   logic [7:0]             s_addr;
   logic [7:0]             s_wdata;
   logic                   s_wren;
   logic [7:0]             s_q;
   logic [7:0]             rom_addr;
   logic [7:0]             rom_q;
   logic [7:0]             ram_addr;
   logic [7:0]             ram_wdata;
   logic                   ram_wren;

   modport master (
      input  start, key, s_q, rom_q,
      output busy, done, fail, s_addr, s_wdata, s_wren, rom_addr, ram_addr, ram_wdata, ram_wren
   );

   modport slave (
      output start, key, s_q, rom_q,
      input  busy, done, fail, s_addr, s_wdata, s_wren, rom_addr, ram_addr, ram_wdata, ram_wren
   );
endinterface

// File: rtl/rc4_decrypt_engine.sv
// RC4 core: S-box init (256 cyc), key schedule (4 cyc/byte), PRGA decrypt (6 cyc/byte); start ignored while busy.
// Optional plaintext ASCII check enabled by RC4_ASCII_CHECK_EN (aborts with fail=1 on the first bad byte).
module rc4_decrypt_engine #(
   parameter int KEY_BYTES = 3,
   parameter int MSG_LEN   = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   rc4_decrypt_engine_if.master        bus
);
   typedef enum logic [3:0] {
      ST_IDLE, ST_INIT, ST_K0, ST_K1, ST_K2, ST_K3,
      ST_P0, ST_P1, ST_P2, ST_P3, ST_P4, ST_P5, ST_DONE
   } state_e;

   localparam logic [7:0] LAST_K    = 8'(MSG_LEN - 1);
   localparam logic [4:0] LAST_KIDX = 5'(KEY_BYTES - 1);

   state_e                 state_q, state_d;
   logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d;
   logic [7:0]             si_q, si_d, sj_q, sj_d, rb_q, rb_d;
   logic [4:0]             kidx_q, kidx_d;
   logic [8*KEY_BYTES-1:0] key_q, key_d;
   logic                   fail_q, fail_d;
   logic [8*KEY_BYTES-1:0] key_shift;
   logic [7:0]             key_byte;
   logic [7:0]             plain;
   logic                   plain_ok;

   // kidx tracks i mod KEY_BYTES without a divider; byte 0 sits in the MSBs
   assign key_shift = key_q << (8 * kidx_q);
   assign key_byte  = key_shift[8*KEY_BYTES-1 -: 8];
   assign plain     = rb_q ^ bus.s_q;

`ifdef RC4_ASCII_CHECK_EN
   assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
`else
   assign plain_ok = 1'b1;
`endif

   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      k_d           = k_q;
      si_d          = si_q;
      sj_d          = sj_q;
      rb_d          = rb_q;
      kidx_d        = kidx_q;
      key_d         = key_q;
      fail_d        = fail_q;
      bus.s_addr    = 8'h00;
      bus.s_wdata   = 8'h00;
      bus.s_wren    = 1'b0;
      bus.rom_addr  = 8'h00;
      bus.ram_addr  = 8'h00;
      bus.ram_wdata = 8'h00;
      bus.ram_wren  = 1'b0;
      bus.busy      = 1'b1;
      bus.done      = 1'b0;
      bus.fail      = fail_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            bus.busy = 1'b0;
            bus.done = (state_q == ST_DONE);
            if (state_q == ST_DONE && fail_q) bus.ram_addr = k_q;
            if (bus.start) begin
               key_d   = bus.key;
               fail_d  = 1'b0;
               i_d     = 8'h00;
               j_d     = 8'h00;
               k_d     = 8'h00;
               kidx_d  = 5'd0;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            bus.s_addr  = i_q;
            bus.s_wdata = i_q;
            bus.s_wren  = 1'b1;
            i_d         = i_q + 8'd1;
            if (i_q == 8'hFF) state_d = ST_K0;
         end
         ST_K0: begin
            bus.s_addr = i_q;
            state_d    = ST_K1;
         end
         ST_K1: begin
            si_d       = bus.s_q;
            j_d        = j_q + bus.s_q + key_byte;
            bus.s_addr = j_q + bus.s_q + key_byte;
            state_d    = ST_K2;
         end
         ST_K2: begin
            sj_d        = bus.s_q;
            bus.s_addr  = i_q;
            bus.s_wdata = bus.s_q;
            bus.s_wren  = 1'b1;
            state_d     = ST_K3;
         end
         ST_K3: begin
            bus.s_addr  = j_q;
            bus.s_wdata = si_q;
            bus.s_wren  = 1'b1;
            i_d         = i_q + 8'd1;
            kidx_d      = (kidx_q == LAST_KIDX) ? 5'd0 : kidx_q + 5'd1;
            if (i_q == 8'hFF) begin
               j_d     = 8'h00;
               k_d     = 8'h00;
               state_d = ST_P0;
            end else begin
               state_d = ST_K0;
            end
         end
         ST_P0: begin
            i_d          = i_q + 8'd1;
            bus.s_addr   = i_q + 8'd1;
            bus.rom_addr = k_q;
            state_d      = ST_P1;
         end
         ST_P1: begin
            si_d         = bus.s_q;
            j_d          = j_q + bus.s_q;
            bus.s_addr   = j_q + bus.s_q;
            bus.rom_addr = k_q;
            state_d      = ST_P2;
         end
         ST_P2: begin
            sj_d         = bus.s_q;
            bus.s_addr   = i_q;
            bus.s_wdata  = bus.s_q;
            bus.s_wren   = 1'b1;
            bus.rom_addr = k_q;
            state_d      = ST_P3;
         end
         ST_P3: begin
            bus.s_addr   = j_q;
            bus.s_wdata  = si_q;
            bus.s_wren   = 1'b1;
            bus.rom_addr = k_q;
            state_d      = ST_P4;
         end
         ST_P4: begin
            bus.s_addr   = si_q + sj_q;
            bus.rom_addr = k_q;
            rb_d         = bus.rom_q;
            state_d      = ST_P5;
         end
         ST_P5: begin
            bus.rom_addr = k_q;
            bus.ram_addr = k_q;
            if (plain_ok) begin
               bus.ram_wdata = plain;
               bus.ram_wren  = 1'b1;
               k_d           = k_q + 8'd1;
               state_d       = (k_q == LAST_K) ? ST_DONE : ST_P0;
            end else begin
               // k is left on the offending byte so ram_addr reports it in DONE
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         i_q     <= 8'h00;
         j_q     <= 8'h00;
         k_q     <= 8'h00;
         si_q    <= 8'h00;
         sj_q    <= 8'h00;
         rb_q    <= 8'h00;
         kidx_q  <= 5'd0;
         key_q   <= '0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         rb_q    <= rb_d;
         kidx_q  <= kidx_d;
         key_q   <= key_d;
         fail_q  <= fail_d;
      end
   end
endmodule

// File: doc/rc4_decrypt_engine.md
Name: rc4_decrypt_engine

Overview:
- Single-FSM RC4 core. Runs, in sequence: S-box init (s[i]=i), key scheduling (swap loop with a KEY_BYTES-long secret key), then PRGA decryption of MSG_LEN bytes.
- Sits in the ksa top level. It is the only master of the s_memory port, so the top-level first/second loop mux is removed.
- Reads ciphertext from an encrypted-message ROM and writes plaintext to a decrypted-message RAM.
- Started by a key-search controller through a start/done handshake.

Parameters:
- KEY_BYTES, 3, secret key length in bytes (1..32); key port width is 8*KEY_BYTES.
- MSG_LEN, 32, number of message bytes to decrypt (1..256).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- key  in  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8]; captured on accepted start.
- s_addr  out  8  S-memory address.
- s_wdata  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.
- s_q  in  8  S-memory read data; valid the cycle after s_addr is presented.
- rom_addr  out  8  ciphertext ROM address.
- rom_q  in  8  ciphertext byte; 1-cycle read latency.
- ram_addr  out  8  plaintext RAM address.
- ram_wdata  out  8  plaintext byte.
- ram_wren  out  1  plaintext RAM write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  high (level) in DONE until the next accepted start or reset.
- fail  out  1  high with done if the optional check aborted the run; otherwise 0.

Behaviour:
- Reset value of every output is 0. Internal i, j, k and captured key are cleared.
- Reset mid-run returns the FSM to IDLE on the same edge; no further writes to S-memory or RAM.
- Start handling:
  - start in IDLE or DONE: captures key, clears done/fail/i/j/k, enters INIT.
  - start while busy: ignored.
- All index arithmetic is 8-bit modulo 256.
- INIT:
  - One write per cycle: s_addr=i, s_wdata=i, s_wren=1, for i=0..255.
  - 256 cycles, then i=0, j=0, enter KSA.
- KSA: 4 cycles per i.
  - K0: s_addr=i.
  - K1: si=s_q; j=j+si+key[i mod KEY_BYTES]; s_addr=new j.
  - K2: sj=s_q; write s[i]=sj.
  - K3: write s[j]=si; i=i+1.
  - After i=255, K3: i=0, j=0, k=0, enter PRGA.
  - i==j: both writes target the same address with the same value; this is legal.
- PRGA: 6 cycles per byte k.
  - P0: i=i+1; s_addr=i+1.
  - P1: si=s_q; j=j+si; s_addr=new j; rom_addr=k.
  - P2: sj=s_q; write s[i]=sj.
  - P3: write s[j]=si.
  - P4: s_addr=si+sj; rom byte latched.
  - P5: f=s_q; ram_addr=k, ram_wdata=rom_byte^f, ram_wren=1; k=k+1.
  - After k=MSG_LEN-1, P5: enter DONE.
- Timing: with start accepted at edge 0, busy=1 for cycles 1..1280+6*MSG_LEN, and done=1 from cycle 1281+6*MSG_LEN.
- Write enables (s_wren, ram_wren) are one-cycle strobes, never asserted in IDLE or DONE.
- At most one S-memory access per cycle.

Optional Feature:
- Macro RC4_ASCII_CHECK_EN.
- Defined: in P5, each plaintext byte must be 0x61..0x7A or 0x20.
  - On violation, the byte is not written (ram_wren stays 0).
  - FSM goes to DONE with fail=1 and done=1.
  - ram_addr holds the offending index k.
- Undefined: no check; fail is constant 0.

Test Plan:
- Reset, then start with KEY_BYTES=3, key=24'h4B6579, MSG_LEN=9, ROM={BB F3 16 E8 D9 40 AF 0A D3}, macro off -> RAM={50 6C 61 69 6E 74 65 78 74} ("Plaintext"); done at cycle 1335; fail=0.
- KEY_BYTES=4, key=32'h57696B69, MSG_LEN=5, ROM={10 21 BF 04 20}, macro on -> RAM={70 65 64 69 61} ("pedia"); fail=0; done at cycle 1311.
- Same as first scenario with macro on -> no RAM write at all; done=1, fail=1, ram_addr=0.
- Assert reset at cycle 600 of a run (KSA phase) -> next cycle all outputs 0, FSM in IDLE. A fresh start then reproduces the first-scenario results exactly.
- Pulse start at cycle 100 of a run -> ignored; done timing and RAM contents unchanged. Start pulse while done=1 -> done drops the next cycle and the new run completes normally.
- Monitor S-memory after INIT (cycle 256) -> s[x]=x for all x. After KSA, the contents are a permutation of 0..255 matching the software model.
